// File: rtl/seq_unsigned_divider.sv
// Restoring radix-2 unsigned divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// One quotient bit per cycle. Divide-by-zero and quotient overflow are reported one cycle after start.
module seq_unsigned_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        of,
  output logic        dz
);

  // EXC is the single wait cycle before a dz/of result is posted; busy stays low in it.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_EXC  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [7:0] dvs_q, dvs_d;
  logic [2:0] cnt_q, cnt_d;
  logic       exc_dz_q, exc_dz_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] rem_q, rem_d;
  logic       of_q, of_d;
  logic       dz_q, dz_d;

  logic [8:0] step_t;
  logic [8:0] step_diff;
  logic       step_ge;
  logic [7:0] step_r;
  logic [7:0] step_q;
  logic       accept;

  // The 9-bit partial remainder is needed because R shifted left can exceed 8 bits before subtracting.
  always_comb begin
    step_t    = {r_q, q_q[7]};
    step_diff = step_t - {1'b0, dvs_q};
    step_ge   = (step_t >= {1'b0, dvs_q});
    step_r    = step_ge ? step_diff[7:0] : step_t[7:0];
    step_q    = {q_q[6:0], step_ge};
  end

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    exc_dz_d = exc_dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quo_d    = quo_q;
    rem_d    = rem_q;
    of_d     = of_q;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          dvs_d = divisor;
          of_d  = 1'b0;
          dz_d  = 1'b0;
          if (divisor == 8'd0) begin
            state_d  = ST_EXC;
            exc_dz_d = 1'b1;
          end else if (dividend[15:8] >= divisor) begin
            state_d  = ST_EXC;
            exc_dz_d = 1'b0;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            r_d     = dividend[15:8];
            q_d     = dividend[7:0];
            cnt_d   = 3'd0;
          end
        end
      end
      ST_RUN: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          quo_d   = step_q;
          rem_d   = step_r;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_EXC: begin
        dz_d    = exc_dz_q;
        of_d    = ~exc_dz_q;
        quo_d   = 8'hFF;
        rem_d   = 8'h00;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      r_q      <= 8'd0;
      q_q      <= 8'd0;
      dvs_q    <= 8'd0;
      cnt_q    <= 3'd0;
      exc_dz_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quo_q    <= 8'd0;
      rem_q    <= 8'd0;
      of_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      exc_dz_q <= exc_dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      of_q     <= of_d;
      dz_q     <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign of        = of_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Bench for seq_unsigned_divider: directed cases followed by random operands checked
// against an arithmetic reference (/, %) including flag and latency expectations.
module tb_seq_unsigned_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        of;
  logic        dz;

  int checks = 0;
  int errors = 0;

  seq_unsigned_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .of        (of),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the start is sampled on the following rising edge.
  task automatic start_job(input logic [15:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done after the accepting edge and compares the result with the arithmetic model.
  // inject_at >= 0 pulses a spurious start with other operands that many cycles into the job.
  task automatic wait_check(input string tag, input logic [15:0] a, input logic [7:0] b,
                            input int inject_at);
    int          lat;
    int          exp_lat;
    logic [7:0]  exp_q;
    logic [7:0]  exp_r;
    logic        exp_of;
    logic        exp_dz;
    logic [16:0] back;
    if (b == 8'd0) begin
      exp_dz = 1'b1; exp_of = 1'b0; exp_q = 8'hFF; exp_r = 8'h00; exp_lat = 1;
    end else if ((32'(a) / 32'(b)) > 32'd255) begin
      exp_dz = 1'b0; exp_of = 1'b1; exp_q = 8'hFF; exp_r = 8'h00; exp_lat = 1;
    end else begin
      exp_dz = 1'b0; exp_of = 1'b0;
      exp_q  = 8'(32'(a) / 32'(b));
      exp_r  = 8'(32'(a) % 32'(b));
      exp_lat = 8;
    end
    lat = 0;
    check({tag, " busy_after_start"}, 32'(busy), 32'(exp_lat == 8));
    check({tag, " done_low_after_start"}, 32'(done), 32'd0);
    while (done !== 1'b1 && lat < 20) begin
      if (lat == inject_at) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, " of"}, 32'(of), 32'(exp_of));
    check({tag, " dz"}, 32'(dz), 32'(exp_dz));
    if (exp_lat == 8) begin
      back = 17'(quotient) * 17'(b) + 17'(remainder);
      check({tag, " multiply_back"}, 32'(back), 32'(a));
    end
    $display("job %s: dividend=%0d divisor=%0d -> q=%0d r=%0d of=%0b dz=%0b lat=%0d",
             tag, a, b, quotient, remainder, of, dz, lat);
  endtask

  // One idle cycle after a done: the pulse must drop and the result must hold.
  task automatic idle_check(input string tag);
    logic [7:0] q_prev;
    logic [7:0] r_prev;
    q_prev = quotient;
    r_prev = remainder;
    @(negedge clk);
    check({tag, " done_dropped"}, 32'(done), 32'd0);
    check({tag, " hold"}, {16'd0, quotient, remainder}, {16'd0, q_prev, r_prev});
  endtask

  initial begin
    int         mode;
    int         dones;
    logic [7:0] rb;
    logic [7:0] rq;
    logic [7:0] rr;
    logic [15:0] ra;

    rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset outputs", {22'd0, busy, done, of, dz, quotient[3:0], remainder[3:0]}, 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);

    // T1
    start_job(16'd1000, 8'd7);
    wait_check("T1", 16'd1000, 8'd7, -1);
    check("T1 q value", 32'(quotient), 32'd142);
    idle_check("T1");
    // T2
    start_job(16'hFE01, 8'hFF);
    wait_check("T2", 16'hFE01, 8'hFF, -1);
    idle_check("T2");
    // T3
    start_job(16'h1234, 8'd0);
    wait_check("T3", 16'h1234, 8'd0, -1);
    idle_check("T3");
    // T4
    start_job(16'h0100, 8'd1);
    wait_check("T4", 16'h0100, 8'd1, -1);
    idle_check("T4");
    // T5: spurious start mid-run
    start_job(16'd1000, 8'd7);
    wait_check("T5", 16'd1000, 8'd7, 2);
    idle_check("T5");

    // T6: reset mid-run aborts without a done pulse
    start_job(16'd5000, 8'd41);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("T6 reset busy", 32'(busy), 32'd0);
    check("T6 reset done", 32'(done), 32'd0);
    check("T6 reset result", {16'd0, quotient, remainder}, 32'd0);
    check("T6 reset flags", {30'd0, of, dz}, 32'd0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("T6 no done after abort", 32'(dones), 32'd0);
    start_job(16'd777, 8'd13);
    wait_check("T6a", 16'd777, 8'd13, -1);
    start_job(16'd65000, 8'd255);
    wait_check("T6b", 16'd65000, 8'd255, -1);
    idle_check("T6b");

    // Random jobs, mixing exception cases and back-to-back starts.
    for (int n = 0; n < 2000; n++) begin
      mode = int'($urandom % 8);
      if (mode == 0) begin
        ra = 16'($urandom); rb = 8'd0;
      end else if (mode == 1) begin
        rb = 8'($urandom_range(1, 255));
        ra = {8'($urandom_range(32'(rb), 255)), 8'($urandom)};
      end else begin
        rb = 8'($urandom_range(1, 255));
        rq = 8'($urandom);
        rr = 8'($urandom_range(0, 32'(rb) - 1));
        ra = 16'(32'(rq) * 32'(rb) + 32'(rr));
      end
      start_job(ra, rb);
      wait_check("RND", ra, rb, -1);
      if ($urandom % 2 == 0) idle_check("RND");
    end
    idle_check("END");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
